byte_unstriping: RTL and testbench
==================================

// Module: byte_unstriping
// PURPOSE
//  RX-side counterpart of the PHY TX byte striper. It merges two byte lanes back into one in-order byte stream.
//  The striper puts even bytes (0,2,4..) on lane_0 and odd bytes on lane_1; this block restores order 0,1,2,3...
//  Each lane has a small FIFO that absorbs lane-to-lane skew. One byte per clk_2f cycle can leave the block.
// PARAMETERS
//  DATA_W    8  byte width of lanes and output
//  DEPTH     4  entries per lane FIFO; power of 2, >=2
//  ALIGN_TO  8  idle cycles in ALIGN before a lone lane_0 byte (odd-length tail) is released
// PORTS
//  clk_2f     in   1       single clock, all logic on rising edge
//  reset      in   1       asynchronous, active-low; 0 clears all state
//  lane_0     in   DATA_W  lane 0 byte (even bytes)
//  valid_0    in   1       lane_0 holds a byte this cycle; push qualifier
//  lane_1     in   DATA_W  lane 1 byte (odd bytes)
//  valid_1    in   1       lane_1 holds a byte this cycle; push qualifier
//  data_out   out  DATA_W  merged byte, registered
//  valid_out  out  1       data_out is a new byte this cycle, registered
//  aligned    out  1       1 while FSM is in RUN
//  err_ovf    out  2       sticky per-lane overflow; bit0 = lane 0, bit1 = lane 1
// BEHAVIOUR
//  Reset (reset=0, async):
//   - data_out=0, valid_out=0, aligned=0, err_ovf=0.
//   - Both FIFOs empty, sel=0, idle counter=0, state=ALIGN.
//  Push:
//   - At an edge with valid_N=1, lane_N is written into FIFO N.
//   - Push is accepted if count_N<DEPTH, or if FIFO N is popped at the same edge (full+push+pop keeps count=DEPTH).
//   - Otherwise the byte is dropped and err_ovf[N] is set to 1; it stays set until reset.
//  Pop decisions:
//   - Pop decisions use registered counts from before the edge.
//   - No bypass: a byte pushed at edge k can be popped at edge k+1 at the earliest.
//   - Minimum input-to-output latency is 2 edges.
//  FSM ALIGN:
//   - aligned=0, sel forced to 0.
//   - If count_0>0 and count_1>0: pop lane 0, data_out<=head_0, valid_out<=1, sel<=1, go to RUN.
//   - Else if count_0>0, count_1==0, valid_0=valid_1=0: increment idle counter.
//   - When the counter reaches ALIGN_TO-1: pop lane 0 alone, valid_out<=1, sel<=0, stay in ALIGN (odd tail byte).
//   - Any other condition clears the idle counter; valid_out<=0, data_out holds its value.
//   - A lane 1 byte with lane 0 empty is held; it is never emitted before its lane 0 partner.
//  FSM RUN:
//   - aligned=1.
//   - If count_sel>0: pop FIFO sel, data_out<=head_sel, valid_out<=1, sel toggles.
//   - Else stall: valid_out<=0, data_out and sel hold.
//   - If count_0==count_1==0 and valid_0=valid_1=0 at an edge with no pop: go to ALIGN, sel<=0, idle counter<=0.
//  Simultaneous events:
//   - Push and pop on the same FIFO at one edge are both honoured.
//   - Overflow on one lane does not stall the other lane or the FSM.
//  Widths:
//   - count_N is clog2(DEPTH)+1 bits.
//   - Read and write pointers are clog2(DEPTH) bits and wrap modulo DEPTH.
//   - Idle counter is clog2(ALIGN_TO)+1 bits and saturates.
//  Reset mid-packet: buffered bytes are discarded and the FSM restarts in ALIGN. There is no partial output after reset.
// TESTING
//  1 Reset: hold reset=0 for 3 cycles with random lane activity.
//    -> all outputs 0, aligned=0. After release, first valid_out only once both lanes hold a byte.
//  2 No skew: lane_0 = 0xA0,0xA2,0xA4; lane_1 = 0xA1,0xA3,0xA5; valid_0/valid_1 high on alternate cycles in step.
//    -> data_out sequence 0xA0..0xA5 in order, aligned=1 during the burst, back to ALIGN after.
//  3 Skew: lane_1 delayed 3 cycles relative to lane_0, payload as in 2.
//    -> identical output order; first valid_out 2 edges after first lane_1 push; no err_ovf.
//  4 Odd tail: single byte 0x5A on lane_0, lane_1 idle.
//    -> valid_out=1 with data_out=0x5A exactly ALIGN_TO edges after the push is visible; state stays ALIGN.
//  5 Overflow: 6 lane_0 pushes with lane_1 idle (DEPTH=4).
//    -> err_ovf=2'b01 after the 5th push and stays set. Then push 4 lane_1 bytes -> 8 bytes out, lane_0 bytes 5-6 lost.
//  6 Stall/full boundary: fill both FIFOs to DEPTH, then push and pop on the same edge.
//    -> counts stay 4, no err_ovf, output ordering unbroken.

Source files
------------

// File: rtl/byte_unstriping_if.sv
// Lane-side and output-side signals of the byte unstriper, bundled for port hookup.
//
// Handshake semantics: valid-only, with no ready and no backpressure.
//  - valid_N=1 at a rising clk_2f edge pushes lane_N into lane FIFO N.
//    A push that finds FIFO N full, with no pop at the same edge, is dropped
//    and flagged in err_ovf[N].
//  - valid_out=1 marks data_out as a new merged byte for exactly that cycle.
//    The consumer must take it; it is never repeated.
// The dbg_* signals expose the FSM state and lane fill levels for observation only.
interface byte_unstriping_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] lane_0;
  logic              valid_0;
  logic [DATA_W-1:0] lane_1;
  logic              valid_1;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic              aligned;
  logic [1:0]        err_ovf;
  logic              dbg_state;
  logic [CNT_W-1:0]  dbg_count_0;
  logic [CNT_W-1:0]  dbg_count_1;

  // The block itself: consumes the lanes and produces the merged stream.
  modport slave (
    input  lane_0, valid_0, lane_1, valid_1,
    output data_out, valid_out, aligned, err_ovf, dbg_state, dbg_count_0, dbg_count_1
  );

  // The environment: drives the lanes and observes the merged stream.
  modport master (
    output lane_0, valid_0, lane_1, valid_1,
    input  data_out, valid_out, aligned, err_ovf, dbg_state, dbg_count_0, dbg_count_1
  );
endinterface

// File: rtl/byte_unstriping.sv
// Byte unstriper: merges the even-byte lane (lane_0) and the odd-byte lane (lane_1)
// back into a single in-order byte stream. Each lane has a small FIFO that absorbs
// skew between the lanes. At most one byte leaves per clk_2f cycle.
module byte_unstriping #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 4,
  parameter int ALIGN_TO = 8
) (
  input  logic              clk_2f,
  input  logic              reset,
  byte_unstriping_if.slave  bus
);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int IDLE_W = $clog2(ALIGN_TO) + 1;

  typedef enum logic [0:0] {
    S_ALIGN = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  // Lane storage and pointers. Index 0 is lane_0 (even bytes); index 1 is lane_1 (odd bytes).
  logic [DATA_W-1:0] mem_q  [2][DEPTH];
  logic [PTR_W-1:0]  wptr_q [2];
  logic [PTR_W-1:0]  wptr_d [2];
  logic [PTR_W-1:0]  rptr_q [2];
  logic [PTR_W-1:0]  rptr_d [2];
  logic [CNT_W-1:0]  cnt_q  [2];
  logic [CNT_W-1:0]  cnt_d  [2];
  logic [DATA_W-1:0] lane_in [2];
  logic [DATA_W-1:0] head    [2];

  logic [1:0]        vld;
  logic [1:0]        push;
  logic [1:0]        pop;
  logic [1:0]        err_q, err_d;

  state_t            state_q, state_d;
  logic              sel_q, sel_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              vout_q, vout_d;
  logic              nz0, nz1, sel_nz;
  logic              lanes_idle;

  assign vld        = {bus.valid_1, bus.valid_0};
  assign lane_in[0] = bus.lane_0;
  assign lane_in[1] = bus.lane_1;
  assign head[0]    = mem_q[0][rptr_q[0]];
  assign head[1]    = mem_q[1][rptr_q[1]];
  assign nz0        = (cnt_q[0] != '0);
  assign nz1        = (cnt_q[1] != '0);
  assign sel_nz     = sel_q ? nz1 : nz0;
  assign lanes_idle = !bus.valid_0 && !bus.valid_1;

  // FSM next state and pop decisions. Uses the registered counts only, so a byte
  // pushed at one edge can be popped at the next edge at the earliest.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    idle_d  = idle_q;
    dout_d  = dout_q;
    vout_d  = 1'b0;
    pop     = 2'b00;
    case (state_q)
      S_ALIGN: begin
        sel_d = 1'b0;
        if (nz0 && nz1) begin
          // A byte pair is present. Emit the even byte and start alternating.
          pop     = 2'b01;
          dout_d  = head[0];
          vout_d  = 1'b1;
          sel_d   = 1'b1;
          idle_d  = '0;
          state_d = S_RUN;
        end else if (nz0 && lanes_idle) begin
          // A lone even byte with quiet lanes may be an odd-length tail.
          // Release it after waiting ALIGN_TO idle cycles.
          if (idle_q == IDLE_W'(ALIGN_TO - 1)) begin
            pop    = 2'b01;
            dout_d = head[0];
            vout_d = 1'b1;
            idle_d = '0;
          end else if (idle_q != '1) begin
            idle_d = idle_q + IDLE_W'(1);
          end
        end else begin
          // An odd byte without its even partner is held here.
          idle_d = '0;
        end
      end
      S_RUN: begin
        if (sel_nz) begin
          pop    = sel_q ? 2'b10 : 2'b01;
          dout_d = sel_q ? head[1] : head[0];
          vout_d = 1'b1;
          sel_d  = !sel_q;
        end else if (!nz0 && !nz1 && lanes_idle) begin
          state_d = S_ALIGN;
          sel_d   = 1'b0;
          idle_d  = '0;
        end
      end
      default: begin
        state_d = S_ALIGN;
        sel_d   = 1'b0;
        idle_d  = '0;
      end
    endcase
  end

  // Per-lane push acceptance, overflow flagging, and pointer/count update.
  // A full FIFO still accepts a push when it is popped at the same edge.
  always_comb begin
    push  = 2'b00;
    err_d = err_q;
    for (int i = 0; i < 2; i++) begin
      push[i]   = vld[i] && ((cnt_q[i] < CNT_W'(DEPTH)) || pop[i]);
      err_d[i]  = err_q[i] | (vld[i] && !push[i]);
      wptr_d[i] = wptr_q[i] + PTR_W'(push[i]);
      rptr_d[i] = rptr_q[i] + PTR_W'(pop[i]);
      cnt_d[i]  = cnt_q[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
    end
  end

  // Control state, output registers and FIFO bookkeeping. Reset is asynchronous.
  always_ff @(posedge clk_2f or negedge reset) begin
    if (!reset) begin
      state_q <= S_ALIGN;
      sel_q   <= 1'b0;
      idle_q  <= '0;
      dout_q  <= '0;
      vout_q  <= 1'b0;
      err_q   <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      idle_q  <= idle_d;
      dout_q  <= dout_d;
      vout_q  <= vout_d;
      err_q   <= err_d;
      for (int i = 0; i < 2; i++) begin
        wptr_q[i] <= wptr_d[i];
        rptr_q[i] <= rptr_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
    end
  end

  // Lane FIFO storage. It has no reset because the counts gate every read.
  always_ff @(posedge clk_2f) begin
    for (int i = 0; i < 2; i++) begin
      if (push[i]) begin
        mem_q[i][wptr_q[i]] <= lane_in[i];
      end
    end
  end

  assign bus.data_out    = dout_q;
  assign bus.valid_out   = vout_q;
  assign bus.aligned     = (state_q == S_RUN);
  assign bus.err_ovf     = err_q;
  assign bus.dbg_state   = state_q;
  assign bus.dbg_count_0 = cnt_q[0];
  assign bus.dbg_count_1 = cnt_q[1];
endmodule

// File: tb/tb_byte_unstriping.sv
// Directed bench for byte_unstriping with DATA_W=8, DEPTH=4 and ALIGN_TO=8.
module tb_byte_unstriping;
  logic clk_2f = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  byte_unstriping_if #(.DATA_W(8), .DEPTH(4)) bif ();

  byte_unstriping #(.DATA_W(8), .DEPTH(4), .ALIGN_TO(8)) dut (
    .clk_2f (clk_2f),
    .reset  (reset),
    .bus    (bif)
  );

  // Clock and reset
  always #5 clk_2f = ~clk_2f;

  // Output monitor: capture every emitted byte on the falling edge.
  always @(negedge clk_2f) begin
    if (reset && bif.valid_out) got_q.push_back(bif.data_out);
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks
  task automatic step(input logic v0, input logic [7:0] d0, input logic v1, input logic [7:0] d1);
    bif.valid_0 = v0;
    bif.lane_0  = d0;
    bif.valid_1 = v1;
    bif.lane_1  = d1;
    @(posedge clk_2f);
    #1;
  endtask

  task automatic idle_step();
    step(1'b0, 8'h00, 1'b0, 8'h00);
  endtask

  task automatic do_reset();
    bif.valid_0 = 1'b0;
    bif.lane_0  = 8'h00;
    bif.valid_1 = 1'b0;
    bif.lane_1  = 8'h00;
    reset = 1'b0;
    repeat (2) @(posedge clk_2f);
    #1;
    reset = 1'b1;
    got_q.delete();
    exp_q.delete();
  endtask

  // Test 1: reset values, holding back a lone odd byte, and asynchronous reset in mid-packet.
  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bif.valid_0 = 1'($urandom_range(0, 1));
      bif.lane_0  = 8'($urandom_range(0, 255));
      bif.valid_1 = 1'($urandom_range(0, 1));
      bif.lane_1  = 8'($urandom_range(0, 255));
      @(posedge clk_2f);
      #1;
    end
    n_cmp++; if (bif.valid_out !== 1'b0) begin n_err++; $display("FAIL rst_valid_out: got %b want 0", bif.valid_out); end
    n_cmp++; if (bif.data_out !== 8'h00) begin n_err++; $display("FAIL rst_data_out: got %h want 00", bif.data_out); end
    n_cmp++; if (bif.aligned !== 1'b0) begin n_err++; $display("FAIL rst_aligned: got %b want 0", bif.aligned); end
    n_cmp++; if (bif.err_ovf !== 2'b00) begin n_err++; $display("FAIL rst_err_ovf: got %b want 00", bif.err_ovf); end
    n_cmp++; if (bif.dbg_count_0 !== 3'd0 || bif.dbg_count_1 !== 3'd0) begin n_err++; $display("FAIL rst_counts: got %0d/%0d want 0/0", bif.dbg_count_0, bif.dbg_count_1); end
    bif.valid_0 = 1'b0;
    bif.valid_1 = 1'b0;
    reset = 1'b1;
    step(1'b0, 8'h00, 1'b1, 8'h77);
    n_cmp++; if (bif.valid_out !== 1'b0) begin n_err++; $display("FAIL hold_l1_push: got valid_out %b want 0", bif.valid_out); end
    for (int i = 0; i < 3; i++) begin
      idle_step();
      n_cmp++; if (bif.valid_out !== 1'b0) begin n_err++; $display("FAIL hold_l1_wait%0d: got valid_out %b want 0", i, bif.valid_out); end
    end
    step(1'b1, 8'h66, 1'b0, 8'h00);
    n_cmp++; if (bif.valid_out !== 1'b0) begin n_err++; $display("FAIL no_bypass: got valid_out %b want 0", bif.valid_out); end
    idle_step();
    n_cmp++; if (bif.valid_out !== 1'b1 || bif.data_out !== 8'h66) begin n_err++; $display("FAIL first_pair_even: got %b/%h want 1/66", bif.valid_out, bif.data_out); end
    n_cmp++; if (bif.aligned !== 1'b1) begin n_err++; $display("FAIL first_pair_aligned: got %b want 1", bif.aligned); end
    idle_step();
    n_cmp++; if (bif.valid_out !== 1'b1 || bif.data_out !== 8'h77) begin n_err++; $display("FAIL first_pair_odd: got %b/%h want 1/77", bif.valid_out, bif.data_out); end
    idle_step();
    n_cmp++; if (bif.valid_out !== 1'b0 || bif.aligned !== 1'b0) begin n_err++; $display("FAIL first_pair_end: got valid %b aligned %b want 0/0", bif.valid_out, bif.aligned); end
    step(1'b1, 8'h11, 1'b1, 8'h22);
    idle_step();
    #1;
    reset = 1'b0;
    #1;
    n_cmp++; if (bif.valid_out !== 1'b0 || bif.data_out !== 8'h00 || bif.aligned !== 1'b0) begin n_err++; $display("FAIL async_reset: got %b/%h/%b want 0/00/0", bif.valid_out, bif.data_out, bif.aligned); end
    n_cmp++; if (bif.dbg_count_1 !== 3'd0) begin n_err++; $display("FAIL async_reset_count1: got %0d want 0", bif.dbg_count_1); end
    @(posedge clk_2f);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idle_step();
      n_cmp++; if (bif.valid_out !== 1'b0) begin n_err++; $display("FAIL post_reset_flush%0d: got valid_out %b want 0", i, bif.valid_out); end
    end
  endtask

  // Test 2: lanes in step, one pair every other cycle.
  task automatic test_no_skew();
    logic       v_t  [9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [7:0] d0_t [9] = '{8'hA0, 8'h00, 8'hA2, 8'h00, 8'hA4, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] d1_t [9] = '{8'hA1, 8'h00, 8'hA3, 8'h00, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00};
    logic       ev_t [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [7:0] ed_t [9] = '{8'h00, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'h00, 8'h00};
    logic       ea_t [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step(v_t[i], d0_t[i], v_t[i], d1_t[i]);
      n_cmp++; if (bif.valid_out !== ev_t[i]) begin n_err++; $display("FAIL noskew_valid e%0d: got %b want %b", i + 1, bif.valid_out, ev_t[i]); end
      n_cmp++; if (bif.aligned !== ea_t[i]) begin n_err++; $display("FAIL noskew_aligned e%0d: got %b want %b", i + 1, bif.aligned, ea_t[i]); end
      if (ev_t[i]) begin
        n_cmp++; if (bif.data_out !== ed_t[i]) begin n_err++; $display("FAIL noskew_data e%0d: got %h want %h", i + 1, bif.data_out, ed_t[i]); end
      end
    end
  endtask

  // Test 3: lane_1 arrives 3 cycles after lane_0.
  task automatic test_skew();
    logic       v0_t [11] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [7:0] d0_t [11] = '{8'hA0, 8'h00, 8'hA2, 8'h00, 8'hA4, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    logic       v1_t [11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [7:0] d1_t [11] = '{8'h00, 8'h00, 8'h00, 8'hA1, 8'h00, 8'hA3, 8'h00, 8'hA5, 8'h00, 8'h00, 8'h00};
    logic       ev_t [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [7:0] ed_t [11] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'h00};
    do_reset();
    for (int i = 0; i < 11; i++) begin
      step(v0_t[i], d0_t[i], v1_t[i], d1_t[i]);
      n_cmp++; if (bif.valid_out !== ev_t[i]) begin n_err++; $display("FAIL skew_valid e%0d: got %b want %b", i + 1, bif.valid_out, ev_t[i]); end
      n_cmp++; if (bif.aligned !== ev_t[i]) begin n_err++; $display("FAIL skew_aligned e%0d: got %b want %b", i + 1, bif.aligned, ev_t[i]); end
      if (ev_t[i]) begin
        n_cmp++; if (bif.data_out !== ed_t[i]) begin n_err++; $display("FAIL skew_data e%0d: got %h want %h", i + 1, bif.data_out, ed_t[i]); end
      end
    end
    n_cmp++; if (bif.err_ovf !== 2'b00) begin n_err++; $display("FAIL skew_err_ovf: got %b want 00", bif.err_ovf); end
  endtask

  // Test 4: a lone even byte is released after the idle timeout.
  task automatic test_odd_tail();
    do_reset();
    step(1'b1, 8'h5A, 1'b0, 8'h00);
    for (int i = 1; i < 8; i++) begin
      idle_step();
      n_cmp++; if (bif.valid_out !== 1'b0) begin n_err++; $display("FAIL tail_early e+%0d: got valid_out %b want 0", i, bif.valid_out); end
    end
    idle_step();
    n_cmp++; if (bif.valid_out !== 1'b1 || bif.data_out !== 8'h5A) begin n_err++; $display("FAIL tail_release: got %b/%h want 1/5a", bif.valid_out, bif.data_out); end
    n_cmp++; if (bif.aligned !== 1'b0 || bif.dbg_state !== 1'b0) begin n_err++; $display("FAIL tail_state: got aligned %b state %b want 0/0", bif.aligned, bif.dbg_state); end
    idle_step();
    n_cmp++; if (bif.valid_out !== 1'b0 || bif.dbg_count_0 !== 3'd0) begin n_err++; $display("FAIL tail_after: got valid %b count0 %0d want 0/0", bif.valid_out, bif.dbg_count_0); end
  endtask

  // Test 5: lane_0 overflow, then lane_1 catches up.
  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 8'(8'h10 + 2 * i), 1'b0, 8'h00);
      if (i == 3) begin
        n_cmp++; if (bif.err_ovf !== 2'b00) begin n_err++; $display("FAIL ovf_before: got %b want 00", bif.err_ovf); end
      end
      if (i == 4) begin
        n_cmp++; if (bif.err_ovf !== 2'b01) begin n_err++; $display("FAIL ovf_set: got %b want 01", bif.err_ovf); end
      end
    end
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 8'(8'h11 + 2 * i));
    for (int i = 0; i < 8; i++) exp_q.push_back(8'(8'h10 + i));
    for (int i = 0; i < 40 && got_q.size() < exp_q.size(); i++) idle_step();
    repeat (3) idle_step();
    n_cmp++; if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL ovf_count: got %0d bytes want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL ovf_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    n_cmp++; if (bif.err_ovf !== 2'b01) begin n_err++; $display("FAIL ovf_sticky: got %b want 01", bif.err_ovf); end
  endtask

  // Test 6: both FIFOs full, with a push and a pop on the same edge.
  task automatic test_full_boundary();
    logic       v0_t [13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [7:0] d0_t [13] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 8'h04, 8'h06, 8'h08, 8'h0A, 8'h0C, 8'h0E, 8'h00};
    logic       v1_t [13] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] d1_t [13] = '{8'h01, 8'h03, 8'h05, 8'h07, 8'h00, 8'h00, 8'h09, 8'h00, 8'h0B, 8'h00, 8'h0D, 8'h00, 8'h0F};
    do_reset();
    for (int i = 0; i < 13; i++) begin
      step(v0_t[i], d0_t[i], v1_t[i], d1_t[i]);
      if (i >= 10) begin
        n_cmp++; if (bif.dbg_count_0 !== 3'd4 || bif.dbg_count_1 !== 3'd4) begin n_err++; $display("FAIL full_counts e%0d: got %0d/%0d want 4/4", i + 1, bif.dbg_count_0, bif.dbg_count_1); end
        n_cmp++; if (bif.err_ovf !== 2'b00) begin n_err++; $display("FAIL full_err e%0d: got %b want 00", i + 1, bif.err_ovf); end
      end
    end
    for (int i = 0; i < 16; i++) exp_q.push_back(8'(i));
    for (int i = 0; i < 40 && got_q.size() < exp_q.size(); i++) idle_step();
    repeat (3) idle_step();
    n_cmp++; if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL full_count_out: got %0d bytes want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL full_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    n_cmp++; if (bif.aligned !== 1'b0) begin n_err++; $display("FAIL full_end_aligned: got %b want 0", bif.aligned); end
  endtask

  // Test sequence and final report
  initial begin
    reset       = 1'b0;
    bif.valid_0 = 1'b0;
    bif.lane_0  = 8'h00;
    bif.valid_1 = 1'b0;
    bif.lane_1  = 8'h00;
    repeat (2) @(posedge clk_2f);
    #1;
    test_reset();
    test_no_skew();
    test_skew();
    test_odd_tail();
    test_overflow();
    test_full_boundary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
